// File: rtl/ram_16k_arbiter.sv
// ram_16k_arbiter: shares one single-port 16K x 16 RAM between requester A
// (CPU data side) and requester B (loader/DMA side). One access per SERVE
// cycle, one-cycle ack plus registered read data back to the served side.
module ram_16k_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        req_a,
    input  logic        we_a,
    input  logic [13:0] addr_a,
    input  logic [15:0] wdata_a,
    output logic        ack_a,
    output logic [15:0] rdata_a,

    input  logic        req_b,
    input  logic        we_b,
    input  logic [13:0] addr_b,
    input  logic [15:0] wdata_b,
    output logic        ack_b,
    output logic [15:0] rdata_b,

    output logic [13:0] ram_addr,
    output logic [15:0] ram_in,
    output logic        ram_load,
    input  logic [15:0] ram_out,

    output logic        busy
);

    typedef enum logic {IDLE, SERVE} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      last_q, last_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic [15:0] rdata_a_q, rdata_a_d;
    logic [15:0] rdata_b_q, rdata_b_d;

    logic        elig_a, elig_b;
    owner_t      winner;

    // A requester whose ack is currently visible is masked so the same
    // request is not granted twice before the requester can drop req.
    assign elig_a = req_a & ~ack_a_q;
    assign elig_b = req_b & ~ack_b_q;

    // Winner selection for a grant taken from IDLE.
    always_comb begin
        winner = OWN_A;
        if (elig_a && elig_b) begin
            if (FIXED_PRIORITY) begin
                winner = OWN_A;
            end else begin
                winner = (last_q == OWN_A) ? OWN_B : OWN_A;
            end
        end else if (elig_b) begin
            winner = OWN_B;
        end
    end

    // Next-state logic: grant from IDLE, complete access and hand over in SERVE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        case (state_q)
            IDLE: begin
                if (elig_a || elig_b) begin
                    state_d = SERVE;
                    owner_d = winner;
                end
            end
            SERVE: begin
                last_d = owner_q;
                if (owner_q == OWN_A) begin
                    ack_a_d = 1'b1;
                    if (!we_a) begin
                        rdata_a_d = ram_out;
                    end
                    // Hand straight over to B when it is waiting: no IDLE bubble.
                    if (req_b) begin
                        owner_d = OWN_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ack_b_d = 1'b1;
                    if (!we_b) begin
                        rdata_b_d = ram_out;
                    end
                    if (req_a) begin
                        owner_d = OWN_A;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state and registered ack/read-data outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_A;
            last_q    <= OWN_B;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= 16'h0000;
            rdata_b_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    // RAM lines follow the owner during SERVE; parked at zero otherwise so a
    // reset mid-access drops ram_load immediately.
    always_comb begin
        ram_addr = 14'h0000;
        ram_in   = 16'h0000;
        ram_load = 1'b0;
        if (state_q == SERVE) begin
            if (owner_q == OWN_A) begin
                ram_addr = addr_a;
                ram_in   = wdata_a;
                ram_load = we_a;
            end else begin
                ram_addr = addr_b;
                ram_in   = wdata_b;
                ram_load = we_b;
            end
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign busy    = (state_q == SERVE);

endmodule

// File: tb/tb_ram_16k_arbiter.sv
// Bench for ram_16k_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1), each with its own RAM model.
module tb_ram_16k_arbiter;

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } txn_t;

    typedef struct {
        int          inst;
        int          port;
        logic        we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic        we;
        logic [15:0] exp;
    } sb_t;

    logic        clock;
    logic        reset_n;
    logic        req_a [2];
    logic        we_a [2];
    logic [13:0] addr_a [2];
    logic [15:0] wdata_a [2];
    logic        ack_a [2];
    logic [15:0] rdata_a [2];
    logic        req_b [2];
    logic        we_b [2];
    logic [13:0] addr_b [2];
    logic [15:0] wdata_b [2];
    logic        ack_b [2];
    logic [15:0] rdata_b [2];
    logic [13:0] ram_addr [2];
    logic [15:0] ram_in [2];
    logic        ram_load [2];
    logic [15:0] ram_out [2];
    logic        busy [2];

    bit [15:0]   mem0 [16384];
    bit [15:0]   mem1 [16384];

    int          wr_cnt [2];
    logic [13:0] wr_addr [2];

    int          checks;
    int          errors;
    sb_t         sbq [4][$];
    logic [15:0] last_rd [4];
    txn_t        la [$];
    txn_t        lb [$];
    int          order [$];
    vec_t        vecs [12];

    ram_16k_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
        .clock(clock), .reset_n(reset_n),
        .req_a(req_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .wdata_a(wdata_a[0]),
        .ack_a(ack_a[0]), .rdata_a(rdata_a[0]),
        .req_b(req_b[0]), .we_b(we_b[0]), .addr_b(addr_b[0]), .wdata_b(wdata_b[0]),
        .ack_b(ack_b[0]), .rdata_b(rdata_b[0]),
        .ram_addr(ram_addr[0]), .ram_in(ram_in[0]), .ram_load(ram_load[0]),
        .ram_out(ram_out[0]), .busy(busy[0])
    );

    ram_16k_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .clock(clock), .reset_n(reset_n),
        .req_a(req_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .wdata_a(wdata_a[1]),
        .ack_a(ack_a[1]), .rdata_a(rdata_a[1]),
        .req_b(req_b[1]), .we_b(we_b[1]), .addr_b(addr_b[1]), .wdata_b(wdata_b[1]),
        .ack_b(ack_b[1]), .rdata_b(rdata_b[1]),
        .ram_addr(ram_addr[1]), .ram_in(ram_in[1]), .ram_load(ram_load[1]),
        .ram_out(ram_out[1]), .busy(busy[1])
    );

    // Single-port RAM models: combinational read, write on the clock edge.
    assign ram_out[0] = mem0[ram_addr[0]];
    assign ram_out[1] = mem1[ram_addr[1]];

    always @(posedge clock) begin
        if (ram_load[0]) mem0[ram_addr[0]] <= ram_in[0];
        if (ram_load[1]) mem1[ram_addr[1]] <= ram_in[1];
    end

    // Count write strobes seen mid-cycle and remember their address.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_load[k]) begin
                wr_cnt[k]  <= wr_cnt[k] + 1;
                wr_addr[k] <= ram_addr[k];
            end
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ack(input int k, input int p, input logic ack, input logic [15:0] rd);
        int  idx;
        sb_t e;
        idx = k * 2 + p;
        if (ack) begin
            chk($sformatf("ack_expected_i%0d_p%0d", k, p), (sbq[idx].size() != 0), 1);
            if (sbq[idx].size() != 0) begin
                e = sbq[idx].pop_front();
                if (e.we) begin
                    chk($sformatf("rdata_held_on_write_i%0d_p%0d", k, p), rd, last_rd[idx]);
                end else begin
                    chk($sformatf("rdata_read_i%0d_p%0d", k, p), rd, e.exp);
                    last_rd[idx] = e.exp;
                end
            end
        end
    endtask

    task automatic monitor();
        for (int k = 0; k < 2; k++) begin
            if (ack_a[k] && ack_b[k]) begin
                chk($sformatf("ack_exclusive_i%0d", k), {ack_a[k], ack_b[k]}, 0);
            end
            check_ack(k, 0, ack_a[k], rdata_a[k]);
            check_ack(k, 1, ack_b[k], rdata_b[k]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        monitor();
    endtask

    function automatic txn_t mk(input logic we, input logic [13:0] a, input logic [15:0] d,
                                input logic [15:0] e);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.exp = e;
        return t;
    endfunction

    task automatic present(input int k, input int p, input txn_t t);
        if (p == 0) begin
            req_a[k] = 1'b1; we_a[k] = t.we; addr_a[k] = t.addr; wdata_a[k] = t.wdata;
        end else begin
            req_b[k] = 1'b1; we_b[k] = t.we; addr_b[k] = t.addr; wdata_b[k] = t.wdata;
        end
        sbq[k * 2 + p].push_back('{t.we, t.exp});
    endtask

    task automatic drop(input int k, input int p);
        if (p == 0) begin
            req_a[k] = 1'b0; we_a[k] = 1'b0;
        end else begin
            req_b[k] = 1'b0; we_b[k] = 1'b0;
        end
    endtask

    // Two requesters each working through their list; a requester moves to its
    // next transaction (or drops req) in the cycle it sees its ack.
    task automatic run_streams(input int k, input int budget, output int cycles, output int busy_lo);
        int ia, ib, na, nb;
        ia = 0; ib = 0; na = la.size(); nb = lb.size();
        order.delete();
        cycles = 0; busy_lo = 0;
        if (na > 0) present(k, 0, la[0]);
        if (nb > 0) present(k, 1, lb[0]);
        while ((ia < na || ib < nb) && cycles < budget) begin
            tick();
            cycles++;
            if (ack_a[k] && ia < na) begin
                order.push_back(0);
                ia++;
                if (ia < na) present(k, 0, la[ia]); else drop(k, 0);
            end
            if (ack_b[k] && ib < nb) begin
                order.push_back(1);
                ib++;
                if (ib < nb) present(k, 1, lb[ib]); else drop(k, 1);
            end
            if (!busy[k] && (ia < na || ib < nb)) busy_lo++;
        end
        chk($sformatf("stream_complete_i%0d", k), (ia < na || ib < nb), 0);
        drop(k, 0);
        drop(k, 1);
    endtask

    initial begin
        int cyc, blo, w0, viol;

        vecs[0]  = '{0, 0, 1'b1, 14'h0123, 16'hBEEF, 16'h0000};
        vecs[1]  = '{0, 0, 1'b0, 14'h0123, 16'h0000, 16'hBEEF};
        vecs[2]  = '{0, 1, 1'b1, 14'h3FFF, 16'hA5A5, 16'h0000};
        vecs[3]  = '{0, 1, 1'b0, 14'h3FFF, 16'h0000, 16'hA5A5};
        vecs[4]  = '{0, 0, 1'b0, 14'h3FFF, 16'h0000, 16'hA5A5};
        vecs[5]  = '{0, 1, 1'b0, 14'h0123, 16'h0000, 16'hBEEF};
        vecs[6]  = '{0, 0, 1'b1, 14'h0000, 16'hFFFF, 16'h0000};
        vecs[7]  = '{0, 1, 1'b0, 14'h0000, 16'h0000, 16'hFFFF};
        vecs[8]  = '{1, 0, 1'b1, 14'h0100, 16'h1111, 16'h0000};
        vecs[9]  = '{1, 1, 1'b0, 14'h0100, 16'h0000, 16'h1111};
        vecs[10] = '{1, 0, 1'b0, 14'h0100, 16'h0000, 16'h1111};
        vecs[11] = '{0, 0, 1'b1, 14'h0001, 16'h1357, 16'h0000};

        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) last_rd[i] = 16'h0000;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
            req_b[k] = 1'b0; we_b[k] = 1'b0; addr_b[k] = '0; wdata_b[k] = '0;
        end

        // Reset state
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ack_a_i%0d", k), ack_a[k], 0);
            chk($sformatf("rst_ack_b_i%0d", k), ack_b[k], 0);
            chk($sformatf("rst_rdata_a_i%0d", k), rdata_a[k], 16'h0000);
            chk($sformatf("rst_rdata_b_i%0d", k), rdata_b[k], 16'h0000);
            chk($sformatf("rst_ram_load_i%0d", k), ram_load[k], 0);
            chk($sformatf("rst_busy_i%0d", k), busy[k], 0);
        end
        reset_n = 1'b1;
        tick();

        // Simultaneous pair from reset (last_owner = B): A then B back-to-back
        la.delete(); lb.delete();
        la.push_back(mk(1'b0, 14'h0200, 16'h0000, 16'h0000));
        lb.push_back(mk(1'b1, 14'h0201, 16'h7777, 16'h0000));
        run_streams(0, 10, cyc, blo);
        chk("pair1_cycles", cyc, 3);
        chk("pair1_len", order.size(), 2);
        if (order.size() == 2) begin
            chk("pair1_first", order[0], 0);
            chk("pair1_second", order[1], 1);
        end

        // B was served last, so A wins the next tie again
        tick();
        la.delete(); lb.delete();
        la.push_back(mk(1'b0, 14'h0201, 16'h0000, 16'h7777));
        lb.push_back(mk(1'b0, 14'h0200, 16'h0000, 16'h0000));
        run_streams(0, 10, cyc, blo);
        chk("pair2_cycles", cyc, 3);
        if (order.size() > 0) chk("pair2_first", order[0], 0);

        // Single accesses from the table: latency, write strobe, read data
        for (int i = 0; i < 12; i++) begin
            tick();
            la.delete(); lb.delete();
            if (vecs[i].port == 0) la.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp));
            else                   lb.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp));
            w0 = wr_cnt[vecs[i].inst];
            run_streams(vecs[i].inst, 8, cyc, blo);
            chk($sformatf("vec%0d_latency", i), cyc, 2);
            chk($sformatf("vec%0d_wr_pulses", i), wr_cnt[vecs[i].inst] - w0, {31'b0, vecs[i].we});
            if (vecs[i].we) chk($sformatf("vec%0d_wr_addr", i), wr_addr[vecs[i].inst], vecs[i].addr);
        end

        // Tie with last_owner = A: round-robin picks B, fixed priority picks A
        tick();
        la.delete(); lb.delete();
        la.push_back(mk(1'b0, 14'h0123, 16'h0000, 16'hBEEF));
        lb.push_back(mk(1'b0, 14'h3FFF, 16'h0000, 16'hA5A5));
        run_streams(0, 10, cyc, blo);
        chk("rr_tie_cycles", cyc, 3);
        if (order.size() > 0) chk("rr_tie_first", order[0], 1);

        tick();
        la.delete(); lb.delete();
        la.push_back(mk(1'b1, 14'h0101, 16'h2222, 16'h0000));
        lb.push_back(mk(1'b0, 14'h0100, 16'h0000, 16'h1111));
        run_streams(1, 10, cyc, blo);
        chk("fp_tie_cycles", cyc, 3);
        if (order.size() > 0) chk("fp_tie_first", order[0], 0);

        // Fixed priority, A keeps re-requesting: B still gets every other slot
        tick();
        la.delete(); lb.delete();
        la.push_back(mk(1'b0, 14'h0101, 16'h0000, 16'h2222));
        la.push_back(mk(1'b1, 14'h0102, 16'h3333, 16'h0000));
        la.push_back(mk(1'b0, 14'h0102, 16'h0000, 16'h3333));
        la.push_back(mk(1'b0, 14'h0100, 16'h0000, 16'h1111));
        lb.push_back(mk(1'b1, 14'h0103, 16'h4444, 16'h0000));
        lb.push_back(mk(1'b0, 14'h0101, 16'h0000, 16'h2222));
        run_streams(1, 20, cyc, blo);
        chk("fp_hold_len", order.size(), 6);
        if (order.size() == 6) begin
            chk("fp_hold_b1_slot", order[1], 1);
            chk("fp_hold_b2_slot", order[3], 1);
        end
        chk("fp_hold_cycles", cyc, 9);

        // Alternating A reads / B writes: one ack per cycle, busy held high
        tick();
        la.delete(); lb.delete();
        for (int i = 0; i < 6; i++) begin
            la.push_back(mk(1'b0, 14'h0001, 16'h0000, 16'h1357));
            lb.push_back(mk(1'b1, 14'h0002, 16'h5555, 16'h0000));
        end
        run_streams(0, 30, cyc, blo);
        chk("alt_cycles", cyc, 13);
        chk("alt_busy_gaps", blo, 0);
        chk("alt_len", order.size(), 12);
        viol = 0;
        for (int i = 1; i < order.size(); i++) if (order[i] == order[i-1]) viol++;
        chk("alt_alternation", viol, 0);
        if (order.size() > 0) chk("alt_first", order[0], 1);
        chk("alt_mem_0002", mem0[14'h0002], 16'h5555);

        // Reset during A's write SERVE: no write, no ack
        tick();
        w0 = wr_cnt[0];
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 14'h0010; wdata_a[0] = 16'h1234;
        tick();
        #1;
        chk("midrst_ram_load_before", ram_load[0], 1);
        chk("midrst_ram_addr_before", ram_addr[0], 14'h0010);
        chk("midrst_busy_before", busy[0], 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_ram_load_after", ram_load[0], 0);
        chk("midrst_busy_after", busy[0], 0);
        drop(0, 0);
        tick();
        chk("midrst_no_ack", ack_a[0], 0);
        chk("midrst_no_write", wr_cnt[0] - w0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            last_rd[i] = 16'h0000;
            sbq[i].delete();
        end
        tick();
        la.delete(); lb.delete();
        la.push_back(mk(1'b0, 14'h0010, 16'h0000, 16'h0000));
        run_streams(0, 8, cyc, blo);
        chk("midrst_read_latency", cyc, 2);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
